lenet_frame_ctrl: RTL and testbench

Frame-level scheduler for the LeNet accelerator. It accepts one inference request at a time from the host over a valid/ready handshake and fires conv_start into the convolution engine. It then tracks the layer completion strobes (conv_done, fc1_done, fc2_done), returns fc_done to the convolution engine, and presents a result handshake to the host. It also runs a per-layer watchdog and performance counters. It sits between the host/testbench control and the lenet core.

---
 rtl/lenet_frame_ctrl_if.sv | 36 +++
 rtl/lenet_frame_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lenet_frame_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_frame_ctrl_if.sv
// Host/engine control bundle for the LeNet frame controller.
// The master side is the host plus the convolution engine; the slave side is the controller.
interface lenet_frame_ctrl_if #(
  parameter int CNT_WIDTH       = 20,
  parameter int FRAME_CNT_WIDTH = 16
);
  logic                       frame_valid;
  logic                       frame_ready;
  logic                       conv_start;
  logic                       conv_done;
  logic                       fc1_done;
  logic                       fc2_done;
  logic                       fc_done;
  logic                       result_valid;
  logic                       result_ready;
  logic                       abort;
  logic                       err_clr;
  logic                       busy;
  logic                       timeout_err;
  logic [1:0]                 err_phase;
  logic [CNT_WIDTH-1:0]       conv_cycles;
  logic [CNT_WIDTH-1:0]       fc_cycles;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

  modport master (
    output frame_valid, conv_done, fc1_done, fc2_done, result_ready, abort, err_clr,
    input  frame_ready, conv_start, fc_done, result_valid, busy, timeout_err, err_phase,
           conv_cycles, fc_cycles, frame_cnt
  );

  modport slave (
    input  frame_valid, conv_done, fc1_done, fc2_done, result_ready, abort, err_clr,
    output frame_ready, conv_start, fc_done, result_valid, busy, timeout_err, err_phase,
           conv_cycles, fc_cycles, frame_cnt
  );
endinterface

// File: rtl/lenet_frame_ctrl.sv
// Frame-level scheduler for the LeNet accelerator. It sequences conv -> fc1 -> fc2 -> retire -> result,
// and runs a per-phase watchdog plus per-frame performance counters.
module lenet_frame_ctrl #(
  parameter int CNT_WIDTH       = 20,
  parameter int TIMEOUT_CYC     = 500000,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              srst,
  lenet_frame_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_CONV, S_FC1, S_FC2, S_RETIRE, S_RESULT, S_ERR
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT_CYC - 1);

  state_e                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       wd_q, wd_d;
  logic [CNT_WIDTH-1:0]       fc_acc_q, fc_acc_d;
  logic [CNT_WIDTH-1:0]       conv_cycles_q, conv_cycles_d;
  logic [CNT_WIDTH-1:0]       fc_cycles_q, fc_cycles_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       aborted_q, aborted_d;
  logic                       timeout_err_q, timeout_err_d;
  logic [1:0]                 err_phase_q, err_phase_d;
  logic                       wd_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign wd_hit = (wd_q == WD_LIMIT);

  // Priority inside each busy phase: abort, then the expected strobe, then the watchdog.
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    fc_acc_d      = fc_acc_q;
    conv_cycles_d = conv_cycles_q;
    fc_cycles_d   = fc_cycles_q;
    frame_cnt_d   = frame_cnt_q;
    aborted_d     = aborted_q;
    timeout_err_d = timeout_err_q;
    err_phase_d   = err_phase_q;
    unique case (state_q)
      S_IDLE: begin
        aborted_d = 1'b0;
        if (io.frame_valid) state_d = S_START;
      end
      S_START: begin
        wd_d = '0;
        if (io.abort) begin
          aborted_d = 1'b1;
          state_d   = S_RETIRE;
        end else begin
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (io.abort) begin
          aborted_d = 1'b1;
          state_d   = S_RETIRE;
        end else if (io.conv_done) begin
          conv_cycles_d = sat_inc(wd_q);
          wd_d          = '0;
          fc_acc_d      = '0;
          state_d       = S_FC1;
        end else if (wd_hit) begin
          timeout_err_d = 1'b1;
          err_phase_d   = 2'd1;
          state_d       = S_ERR;
        end else begin
          wd_d = sat_inc(wd_q);
        end
      end
      S_FC1: begin
        fc_acc_d = sat_inc(fc_acc_q);
        if (io.abort) begin
          aborted_d = 1'b1;
          state_d   = S_RETIRE;
        end else if (io.fc1_done) begin
          wd_d    = '0;
          state_d = S_FC2;
        end else if (wd_hit) begin
          timeout_err_d = 1'b1;
          err_phase_d   = 2'd2;
          state_d       = S_ERR;
        end else begin
          wd_d = sat_inc(wd_q);
        end
      end
      S_FC2: begin
        fc_acc_d = sat_inc(fc_acc_q);
        if (io.abort) begin
          aborted_d = 1'b1;
          state_d   = S_RETIRE;
        end else if (io.fc2_done) begin
          fc_cycles_d = sat_inc(fc_acc_q);
          state_d     = S_RETIRE;
        end else if (wd_hit) begin
          timeout_err_d = 1'b1;
          err_phase_d   = 2'd3;
          state_d       = S_ERR;
        end else begin
          wd_d = sat_inc(wd_q);
        end
      end
      S_RETIRE: begin
        // Aborted frames still release memory via fc_done but never count or present a result.
        if (aborted_q) begin
          state_d = S_IDLE;
        end else begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (io.result_ready) state_d = S_IDLE;
      end
      S_ERR: begin
        if (io.err_clr) begin
          timeout_err_d = 1'b0;
          err_phase_d   = 2'd0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q       <= S_IDLE;
      wd_q          <= '0;
      fc_acc_q      <= '0;
      conv_cycles_q <= '0;
      fc_cycles_q   <= '0;
      frame_cnt_q   <= '0;
      aborted_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_phase_q   <= 2'd0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      fc_acc_q      <= fc_acc_d;
      conv_cycles_q <= conv_cycles_d;
      fc_cycles_q   <= fc_cycles_d;
      frame_cnt_q   <= frame_cnt_d;
      aborted_q     <= aborted_d;
      timeout_err_q <= timeout_err_d;
      err_phase_q   <= err_phase_d;
    end
  end

  assign io.frame_ready  = (state_q == S_IDLE);
  assign io.conv_start   = (state_q == S_START);
  assign io.fc_done      = (state_q == S_RETIRE);
  assign io.result_valid = (state_q == S_RESULT);
  assign io.busy         = (state_q != S_IDLE) && (state_q != S_ERR);
  assign io.timeout_err  = timeout_err_q;
  assign io.err_phase    = err_phase_q;
  assign io.conv_cycles  = conv_cycles_q;
  assign io.fc_cycles    = fc_cycles_q;
  assign io.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_lenet_frame_ctrl.sv
// Scoreboard bench for lenet_frame_ctrl: a long-timeout instance for frame sequencing
// and a 64-cycle-timeout instance for the watchdog.
module tb_lenet_frame_ctrl;

  localparam int EV_START = 0;
  localparam int EV_FCD   = 1;
  localparam int EV_RES   = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
    int c;
  } ev_t;

  logic clk;
  logic srst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  ev_t  q[$];
  ev_t  wq[$];
  logic rv_prev;
  logic te_prev;

  lenet_frame_ctrl_if #(.CNT_WIDTH(20), .FRAME_CNT_WIDTH(16)) io ();
  lenet_frame_ctrl_if #(.CNT_WIDTH(20), .FRAME_CNT_WIDTH(16)) wio ();

  lenet_frame_ctrl #(.CNT_WIDTH(20), .TIMEOUT_CYC(500000), .FRAME_CNT_WIDTH(16)) u_dut (
    .clk (clk),
    .srst(srst),
    .io  (io.slave)
  );

  lenet_frame_ctrl #(.CNT_WIDTH(20), .TIMEOUT_CYC(64), .FRAME_CNT_WIDTH(16)) u_wd (
    .clk (clk),
    .srst(srst),
    .io  (wio.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input int kind, input int t, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.cyc = t; e.a = a; e.b = b; e.c = c;
    if (which == 0) q.push_back(e);
    else wq.push_back(e);
  endtask

  task automatic mon_ev(input int which, input int kind, input int a, input int b, input int c);
    ev_t e;
    if ((which == 0 && q.size() == 0) || (which == 1 && wq.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      if (which == 0) e = q.pop_front();
      else e = wq.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (e.kind == EV_RES) begin
        chk("conv_cycles", a, e.a);
        chk("fc_cycles", b, e.b);
        chk("frame_cnt", c, e.c);
      end else if (e.kind == EV_ERR) begin
        chk("err_phase", a, e.a);
      end
    end
  endtask

  // Monitor: every observable event on either DUT must match the head of its queue.
  always @(negedge clk) begin
    if (!srst) begin
      if (io.conv_start) mon_ev(0, EV_START, 0, 0, 0);
      if (io.fc_done) mon_ev(0, EV_FCD, 0, 0, 0);
      if (io.result_valid && !rv_prev)
        mon_ev(0, EV_RES, int'(io.conv_cycles), int'(io.fc_cycles), int'(io.frame_cnt));
      if (wio.timeout_err && !te_prev) mon_ev(1, EV_ERR, int'(wio.err_phase), 0, 0);
    end
    rv_prev = io.result_valid;
    te_prev = wio.timeout_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) tick();
  endtask

  // sel bits: 0 frame_valid, 1 conv_done, 2 fc1_done, 3 fc2_done, 4 abort, 5 result_ready,
  // 6 err_clr; bit 7 steers the pulse to the watchdog instance.
  task automatic drive(input int sel, input logic v);
    if (sel[7]) begin
      if (sel[0]) wio.frame_valid  = v;
      if (sel[1]) wio.conv_done    = v;
      if (sel[2]) wio.fc1_done     = v;
      if (sel[3]) wio.fc2_done     = v;
      if (sel[4]) wio.abort        = v;
      if (sel[5]) wio.result_ready = v;
      if (sel[6]) wio.err_clr      = v;
    end else begin
      if (sel[0]) io.frame_valid  = v;
      if (sel[1]) io.conv_done    = v;
      if (sel[2]) io.fc1_done     = v;
      if (sel[3]) io.fc2_done     = v;
      if (sel[4]) io.abort        = v;
      if (sel[5]) io.result_ready = v;
      if (sel[6]) io.err_clr      = v;
    end
  endtask

  task automatic pulse(input int t, input int sel);
    go_to(t);
    drive(sel, 1'b1);
    tick();
    drive(sel, 1'b0);
  endtask

  initial begin
    int t0, r, c, d, e, f, w, x;
    cyc = 0; n_cmp = 0; n_err = 0; rv_prev = 1'b0; te_prev = 1'b0;
    srst = 1'b1;
    drive(8'h7f, 1'b0);
    drive(8'hff, 1'b0);
    tick(); tick(); tick();
    chk("rst_frame_ready", io.frame_ready, 1);
    chk("rst_busy", io.busy, 0);
    chk("rst_result_valid", io.result_valid, 0);
    chk("rst_frame_cnt", io.frame_cnt, 0);
    chk("rst_conv_cycles", io.conv_cycles, 0);
    srst = 1'b0;
    tick();
    chk("post_rst_frame_ready", io.frame_ready, 1);
    t0 = cyc;

    // Nominal frame with hand-computed latencies and perf counters.
    push(0, EV_START, t0 + 11, 0, 0, 0);
    push(0, EV_FCD, t0 + 1401, 0, 0, 0);
    push(0, EV_RES, t0 + 1402, 989, 400, 1);
    pulse(t0 + 10, 1);
    go_to(t0 + 500);
    chk("conv_busy", io.busy, 1);
    pulse(t0 + 1000, 2);
    pulse(t0 + 1300, 4);
    pulse(t0 + 1400, 8);

    // Result backpressure; a request meanwhile must not start a frame.
    go_to(t0 + 1402);
    for (int i = 0; i < 50; i++) begin
      io.frame_valid = (i >= 10 && i < 20);
      tick();
      if (i % 10 == 9) begin
        chk("bp_result_valid", io.result_valid, 1);
        chk("bp_frame_ready", io.frame_ready, 0);
      end
    end
    io.frame_valid = 1'b0;
    r = cyc;
    pulse(r, 32);
    chk("rel_frame_ready", io.frame_ready, 1);
    chk("rel_result_valid", io.result_valid, 0);

    // Out-of-phase strobes in CONV and FC1 are ignored.
    c = cyc;
    push(0, EV_START, c + 1, 0, 0, 0);
    push(0, EV_FCD, c + 21, 0, 0, 0);
    push(0, EV_RES, c + 22, 9, 10, 2);
    pulse(c, 1);
    pulse(c + 5, 8);
    pulse(c + 7, 4);
    go_to(c + 8);
    chk("ooo_busy", io.busy, 1);
    pulse(c + 10, 2 | 4);
    pulse(c + 12, 2);
    pulse(c + 13, 8);
    pulse(c + 15, 4);
    pulse(c + 20, 8);
    pulse(c + 22, 32);
    chk("ooo_idle", io.frame_ready, 1);

    // Abort in FC2.
    d = cyc;
    push(0, EV_START, d + 1, 0, 0, 0);
    push(0, EV_FCD, d + 10, 0, 0, 0);
    pulse(d, 1);
    pulse(d + 4, 2);
    pulse(d + 6, 4);
    go_to(d + 9);
    chk("fc2_busy", io.busy, 1);
    pulse(d + 9, 16);
    chk("abort_retire_not_ready", io.frame_ready, 0);
    tick();
    chk("abort_idle", io.frame_ready, 1);
    chk("abort_frame_cnt", io.frame_cnt, 2);
    chk("abort_conv_cycles", io.conv_cycles, 3);
    chk("abort_fc_cycles", io.fc_cycles, 10);

    // Abort together with fc2_done: abort wins, fc_cycles not latched.
    e = cyc;
    push(0, EV_START, e + 1, 0, 0, 0);
    push(0, EV_FCD, e + 8, 0, 0, 0);
    pulse(e, 1);
    pulse(e + 3, 2);
    pulse(e + 4, 4);
    pulse(e + 7, 8 | 16);
    tick();
    chk("abort2_idle", io.frame_ready, 1);
    chk("abort2_frame_cnt", io.frame_cnt, 2);
    chk("abort2_fc_cycles", io.fc_cycles, 10);
    chk("abort2_conv_cycles", io.conv_cycles, 2);

    // Async reset mid-CONV, checked before the next clock edge.
    f = cyc;
    push(0, EV_START, f + 1, 0, 0, 0);
    pulse(f, 1);
    go_to(f + 5);
    #2 srst = 1'b1;
    #1;
    chk("arst_frame_ready", io.frame_ready, 1);
    chk("arst_busy", io.busy, 0);
    chk("arst_frame_cnt", io.frame_cnt, 0);
    chk("arst_conv_cycles", io.conv_cycles, 0);
    chk("arst_fc_cycles", io.fc_cycles, 0);
    tick();
    srst = 1'b0;
    tick();
    chk("arst_rel_frame_ready", io.frame_ready, 1);
    chk("arst_rel_busy", io.busy, 0);

    // Watchdog (TIMEOUT_CYC=64): withhold fc1_done.
    w = cyc;
    push(1, EV_ERR, w + 68, 2, 0, 0);
    pulse(w, 128 | 1);
    pulse(w + 3, 128 | 2);
    go_to(w + 67);
    chk("wd_fc1_busy", wio.busy, 1);
    chk("wd_no_err_yet", wio.timeout_err, 0);
    go_to(w + 70);
    chk("err_busy", wio.busy, 0);
    chk("err_frame_ready", wio.frame_ready, 0);
    chk("err_timeout", wio.timeout_err, 1);
    chk("err_phase_lvl", wio.err_phase, 2);
    chk("err_conv_cycles", wio.conv_cycles, 2);
    pulse(w + 70, 128 | 64);
    chk("clr_frame_ready", wio.frame_ready, 1);
    chk("clr_timeout", wio.timeout_err, 0);
    chk("clr_phase", wio.err_phase, 0);

    // Strobe on the watchdog's last cycle wins over the timeout.
    x = cyc;
    pulse(x, 128 | 1);
    pulse(x + 65, 128 | 2);
    go_to(x + 67);
    chk("edge_busy", wio.busy, 1);
    chk("edge_no_err", wio.timeout_err, 0);
    chk("edge_conv_cycles", wio.conv_cycles, 64);
    pulse(x + 67, 128 | 16);
    tick();
    chk("edge_abort_idle", wio.frame_ready, 1);

    tick(); tick();
    chk("queue_drained", q.size(), 0);
    chk("wd_queue_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
